// File: rtl/id_stage_if.sv
// Decode-stage bus: fetch inputs, register file read port, writeback
// bypass, EX hazard info and the ID/EX pipeline register outputs.
interface id_stage_if #(
   parameter int XLEN = 32
);
   logic            if_valid;
   logic [XLEN-1:0] if_instr;
   logic [XLEN-1:0] if_pc;
   logic            flush;
   logic            stall;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;
   logic            wb_we;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_wd;
   logic            ex_mem_read;
   logic [4:0]      ex_rd;
   logic            id_valid;
   logic [XLEN-1:0] id_pc;
   logic [XLEN-1:0] id_rs1_val;
   logic [XLEN-1:0] id_rs2_val;
   logic [XLEN-1:0] id_imm;
   logic [4:0]      id_rd;
   logic [3:0]      id_alu_op;
   logic            id_alu_src;
   logic            id_mem_read;
   logic            id_mem_write;
   logic            id_reg_write;
   logic            id_branch;
   logic            id_illegal;

   // Environment side: fetch, register file, writeback and EX stage
   modport master (
      output if_valid, if_instr, if_pc, flush, rd1, rd2, wb_we, wb_rd, wb_wd,
             ex_mem_read, ex_rd,
      input  stall, rs1, rs2, id_valid, id_pc, id_rs1_val, id_rs2_val, id_imm,
             id_rd, id_alu_op, id_alu_src, id_mem_read, id_mem_write,
             id_reg_write, id_branch, id_illegal
   );

   // Decode stage side
   modport slave (
      input  if_valid, if_instr, if_pc, flush, rd1, rd2, wb_we, wb_rd, wb_wd,
             ex_mem_read, ex_rd,
      output stall, rs1, rs2, id_valid, id_pc, id_rs1_val, id_rs2_val, id_imm,
             id_rd, id_alu_op, id_alu_src, id_mem_read, id_mem_write,
             id_reg_write, id_branch, id_illegal
   );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: register file addressing, writeback bypass,
// immediate/control generation, load-use stall and the ID/EX register.
module id_stage #(
   parameter int XLEN = 32
) (
   input logic        clk,
   input logic        rst,
   id_stage_if.slave  bus
);
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB  = 4'd1, ALU_SLL = 4'd2;
   localparam logic [3:0] ALU_SLT = 4'd3,  ALU_SLTU = 4'd4, ALU_XOR = 4'd5;
   localparam logic [3:0] ALU_SRL = 4'd6,  ALU_SRA  = 4'd7, ALU_OR  = 4'd8;
   localparam logic [3:0] ALU_AND = 4'd9,  ALU_PASSB = 4'd10;

   // ALU operation from funct3; alt_sub picks SUB for 000, alt_sra picks SRA for 101
   function automatic logic [3:0] alu_from_f3(input logic [2:0] f3,
                                              input logic alt_sub,
                                              input logic alt_sra);
      logic [3:0] op;
      case (f3)
         3'b000:  op = alt_sub ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt_sra ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   logic [31:0]     instr_s;
   logic [6:0]      opcode_s;
   logic [2:0]      funct3_s;
   logic [6:0]      funct7_s;
   logic [4:0]      rs1_s, rs2_s, rdf_s;
   logic [31:0]     imm_i_s, imm_st_s, imm_b_s, imm_u_s;
   logic            illegal_s, alu_src_s, mem_read_s, mem_write_s, reg_write_s, branch_s;
   logic            use_rs1_s, use_rs2_s, stall_s;
   logic [3:0]      alu_op_s;
   logic [31:0]     imm_s;
   logic [4:0]      rd_s;
   logic [XLEN-1:0] op1_s, op2_s;

   logic            valid_r, alu_src_r, mem_read_r, mem_write_r, reg_write_r, branch_r, illegal_r;
   logic [XLEN-1:0] pc_r, rs1_val_r, rs2_val_r, imm_r;
   logic [4:0]      rd_r;
   logic [3:0]      alu_op_r;

   assign instr_s  = bus.if_instr;
   assign opcode_s = instr_s[6:0];
   assign funct3_s = instr_s[14:12];
   assign funct7_s = instr_s[31:25];
   assign rs1_s    = instr_s[19:15];
   assign rs2_s    = instr_s[24:20];
   assign rdf_s    = instr_s[11:7];
   assign imm_i_s  = {{20{instr_s[31]}}, instr_s[31:20]};
   assign imm_st_s = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
   assign imm_b_s  = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25],
                      instr_s[11:8], 1'b0};
   assign imm_u_s  = {instr_s[31:12], 12'b0};

   assign bus.rs1 = rs1_s;
   assign bus.rs2 = rs2_s;

   // Instruction decode: legality, control, immediate and source usage
   always_comb begin
      illegal_s   = 1'b1;
      alu_op_s    = ALU_ADD;
      alu_src_s   = 1'b0;
      mem_read_s  = 1'b0;
      mem_write_s = 1'b0;
      reg_write_s = 1'b0;
      branch_s    = 1'b0;
      use_rs1_s   = 1'b0;
      use_rs2_s   = 1'b0;
      imm_s       = 32'd0;
      rd_s        = 5'd0;
      case (opcode_s)
         OPC_OP: begin
            if ((funct7_s == 7'b0000000) ||
                ((funct7_s == 7'b0100000) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)))) begin
               illegal_s   = 1'b0;
               alu_op_s    = alu_from_f3(funct3_s, funct7_s[5], funct7_s[5]);
               reg_write_s = 1'b1;
               use_rs1_s   = 1'b1;
               use_rs2_s   = 1'b1;
               rd_s        = rdf_s;
            end else begin
               illegal_s = 1'b1;
            end
         end
         OPC_OPIMM: begin
            if (((funct3_s != 3'b001) && (funct3_s != 3'b101)) ||
                (funct7_s == 7'b0000000) ||
                ((funct3_s == 3'b101) && (funct7_s == 7'b0100000))) begin
               illegal_s   = 1'b0;
               alu_op_s    = alu_from_f3(funct3_s, 1'b0, funct7_s[5]);
               alu_src_s   = 1'b1;
               reg_write_s = 1'b1;
               use_rs1_s   = 1'b1;
               imm_s       = imm_i_s;
               rd_s        = rdf_s;
            end else begin
               illegal_s = 1'b1;
            end
         end
         OPC_LOAD: begin
            if (funct3_s == 3'b010) begin
               illegal_s   = 1'b0;
               alu_src_s   = 1'b1;
               mem_read_s  = 1'b1;
               reg_write_s = 1'b1;
               use_rs1_s   = 1'b1;
               imm_s       = imm_i_s;
               rd_s        = rdf_s;
            end else begin
               illegal_s = 1'b1;
            end
         end
         OPC_STORE: begin
            if (funct3_s == 3'b010) begin
               illegal_s   = 1'b0;
               alu_src_s   = 1'b1;
               mem_write_s = 1'b1;
               use_rs1_s   = 1'b1;
               use_rs2_s   = 1'b1;
               imm_s       = imm_st_s;
            end else begin
               illegal_s = 1'b1;
            end
         end
         OPC_BRANCH: begin
            if ((funct3_s == 3'b000) || (funct3_s == 3'b001)) begin
               illegal_s = 1'b0;
               alu_op_s  = ALU_SUB;
               branch_s  = 1'b1;
               use_rs1_s = 1'b1;
               use_rs2_s = 1'b1;
               imm_s     = imm_b_s;
            end else begin
               illegal_s = 1'b1;
            end
         end
         OPC_LUI: begin
            illegal_s   = 1'b0;
            alu_op_s    = ALU_PASSB;
            alu_src_s   = 1'b1;
            reg_write_s = 1'b1;
            imm_s       = imm_u_s;
            rd_s        = rdf_s;
         end
         default: illegal_s = 1'b1;
      endcase
   end

   // Operand select: x0 reads zero, a same-cycle writeback overrides the regfile
   always_comb begin
      op1_s = '0;
      op2_s = '0;
      if (rs1_s == 5'd0) begin
         op1_s = '0;
      end else if (bus.wb_we && (bus.wb_rd == rs1_s)) begin
         op1_s = bus.wb_wd;
      end else begin
         op1_s = bus.rd1;
      end
      if (rs2_s == 5'd0) begin
         op2_s = '0;
      end else if (bus.wb_we && (bus.wb_rd == rs2_s)) begin
         op2_s = bus.wb_wd;
      end else begin
         op2_s = bus.rd2;
      end
   end

   // Load-use hazard; a flush squashes the instruction so it never stalls
   assign stall_s = bus.if_valid && !bus.flush && bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                    ((use_rs1_s && (bus.ex_rd == rs1_s)) || (use_rs2_s && (bus.ex_rd == rs2_s)));
   assign bus.stall = stall_s;

   // ID/EX register: reset, then flush/stall/empty bubble, then illegal marker, then issue
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r <= 1'b0; pc_r <= '0; rs1_val_r <= '0; rs2_val_r <= '0; imm_r <= '0;
         rd_r <= 5'd0; alu_op_r <= 4'd0; alu_src_r <= 1'b0; mem_read_r <= 1'b0;
         mem_write_r <= 1'b0; reg_write_r <= 1'b0; branch_r <= 1'b0; illegal_r <= 1'b0;
      end else if (bus.flush || stall_s || !bus.if_valid) begin
         valid_r <= 1'b0; pc_r <= '0; rs1_val_r <= '0; rs2_val_r <= '0; imm_r <= '0;
         rd_r <= 5'd0; alu_op_r <= 4'd0; alu_src_r <= 1'b0; mem_read_r <= 1'b0;
         mem_write_r <= 1'b0; reg_write_r <= 1'b0; branch_r <= 1'b0; illegal_r <= 1'b0;
      end else if (illegal_s) begin
         valid_r <= 1'b1; pc_r <= bus.if_pc; rs1_val_r <= '0; rs2_val_r <= '0; imm_r <= '0;
         rd_r <= 5'd0; alu_op_r <= 4'd0; alu_src_r <= 1'b0; mem_read_r <= 1'b0;
         mem_write_r <= 1'b0; reg_write_r <= 1'b0; branch_r <= 1'b0; illegal_r <= 1'b1;
      end else begin
         valid_r <= 1'b1; pc_r <= bus.if_pc; rs1_val_r <= op1_s; rs2_val_r <= op2_s;
         imm_r <= imm_s; rd_r <= rd_s; alu_op_r <= alu_op_s; alu_src_r <= alu_src_s;
         mem_read_r <= mem_read_s; mem_write_r <= mem_write_s; reg_write_r <= reg_write_s;
         branch_r <= branch_s; illegal_r <= 1'b0;
      end
   end

   assign bus.id_valid     = valid_r;
   assign bus.id_pc        = pc_r;
   assign bus.id_rs1_val   = rs1_val_r;
   assign bus.id_rs2_val   = rs2_val_r;
   assign bus.id_imm       = imm_r;
   assign bus.id_rd        = rd_r;
   assign bus.id_alu_op    = alu_op_r;
   assign bus.id_alu_src   = alu_src_r;
   assign bus.id_mem_read  = mem_read_r;
   assign bus.id_mem_write = mem_write_r;
   assign bus.id_reg_write = reg_write_r;
   assign bus.id_branch    = branch_r;
   assign bus.id_illegal   = illegal_r;
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- RV32I decode stage that sits directly upstream of the register file.
- Drives the register file read addresses (rs1/rs2) and consumes the read data (rd1/rd2).
- Bypasses same-cycle writeback data, generates immediates and control, detects load-use hazards, and registers everything into the ID/EX pipeline register consumed by the execute stage.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
if_valid  in  1  if_instr/if_pc hold a valid instruction
if_instr  in  32  instruction from fetch
if_pc  in  32  PC of if_instr
flush  in  1  squash the instruction in decode (branch taken)
stall  out  1  combinational load-use stall; fetch must hold if_instr/if_pc
rs1  out  5  register file read address 1, combinational = if_instr[19:15]
rs2  out  5  register file read address 2, combinational = if_instr[24:20]
rd1  in  32  register file read data 1 (combinational read)
rd2  in  32  register file read data 2
wb_we  in  1  writeback write enable (same cycle as the regfile write)
wb_rd  in  5  writeback destination
wb_wd  in  32  writeback data
ex_mem_read  in  1  instruction currently in EX is a load
ex_rd  in  5  destination of the instruction in EX
id_valid  out  1  ID/EX holds an instruction
id_pc  out  32  registered PC
id_rs1_val  out  32  registered operand 1
id_rs2_val  out  32  registered operand 2
id_imm  out  32  registered sign-extended immediate
id_rd  out  5  registered destination
id_alu_op  out  4  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 PASSB=10
id_alu_src  out  1  1 selects id_imm as ALU operand B
id_mem_read, id_mem_write, id_reg_write, id_branch  out  1 each  registered control
id_illegal  out  1  unsupported encoding

Behaviour:
- Reset (async assert): every registered output is 0; stall is combinational and is not reset.
- Supported opcodes:
  - OP 0110011: all ten R-type ops; funct7[5] selects SUB/SRA.
  - OP-IMM 0010011: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - LOAD 0000011: funct3=010 (LW) only.
  - STORE 0100011: funct3=010 (SW) only.
  - BRANCH 1100011: funct3 000/001 (BEQ/BNE); alu_op=SUB, id_branch=1.
  - LUI 0110111: alu_op=PASSB, alu_src=1.
  - LW/SW: alu_op=ADD, alu_src=1.
- Immediates (all sign-extended from bit 31):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - R-type: 0.
- Register use: rs1 is used by R, I, LW, SW, B. rs2 is used by R, SW, B. LUI uses neither.
- Operand select: operand = (wb_we && wb_rd!=0 && wb_rd==rsN) ? wb_wd : rdN. A source index of 0 always yields 0.
- Hazard: stall = if_valid && !flush && ex_mem_read && ex_rd!=0 && ((uses rs1 && ex_rd==rs1) || (uses rs2 && ex_rd==rs2)).
- Each rising clk, priority order:
  - flush: id_valid<=0 and all control/data outputs <=0.
  - stall or !if_valid: same bubble.
  - illegal encoding: id_valid<=1, id_illegal<=1, id_pc<=if_pc, all other control 0, data fields 0.
  - otherwise: load the decoded fields; id_illegal<=0.
- Latency: 1 cycle from if_instr to the ID/EX outputs.
- Stall is asserted for exactly as long as the hazard condition holds; the held instruction issues on the first edge after it clears.
- flush and stall together: flush wins and stall reads 0.
- Reset mid-operation clears ID/EX immediately, without waiting for a clock edge.

Test Plan:
1. Assert rst mid-stream with if_valid=1 and ADDI in decode -> all id_* outputs read 0 before the next edge; after release, first edge loads normally.
2. if_instr=0x00500093 (addi x1,x0,5), if_pc=0x100 -> next cycle: id_valid=1, id_pc=0x100, id_rd=1, id_imm=5, id_alu_op=0, id_alu_src=1, id_reg_write=1, id_rs1_val=0.
3. if_instr=0xFE20AE23 (sw x2,-4(x1)) -> id_imm=0xFFFFFFFC, id_mem_write=1, id_reg_write=0, rs1=1, rs2=2.
4. if_instr=0x002101B3 (add x3,x2,x2), rd1=rd2=0, wb_we=1, wb_rd=2, wb_wd=99 -> id_rs1_val=id_rs2_val=99. Repeat with wb_rd=0 -> both values 0.
5. Load-use:
   - if_instr=0x002081B3 (add x3,x1,x2), ex_mem_read=1, ex_rd=1 -> stall=1 same cycle; next cycle id_valid=0.
   - Drop ex_mem_read -> stall=0; next cycle id_valid=1, id_rd=3.
   - ex_rd=0 with ex_mem_read=1 -> no stall.
6. flush=1 together with the hazard above -> stall=0, next id_valid=0. if_instr=0xFFFFFFFF -> id_valid=1, id_illegal=1, id_reg_write=id_mem_write=0.
